// File: rtl/gmii_ptp_parser.sv
// gmii_ptp_parser
//   Watches a GMII transmit byte stream. It checks the preamble and SFD, counts
//   frame bytes, and recognises PTPv2 messages carried either directly over
//   Ethernet (type 0x88F7) or over IPv4/UDP (destination port 319 or 320).
//   The RTC time at the SFD byte is held, and it is reported with the PTP
//   messageType and sequenceId as a one-cycle result pulse per frame.
//
// Build option
//   GMII_PTP_VLAN_EN : when defined, a single 802.1Q tag (0x8100) is skipped,
//                      which shifts every header offset by 4 bytes. When it is
//                      not defined, tagged frames are treated as non-PTP.
//
// Parameters
//   TS_W     width of rtc_time / ptp_ts (48-bit seconds + 32-bit nanoseconds)
//   PRE_MAX  maximum number of 0x55 preamble bytes accepted before the SFD
//
// Ports
//   gmii_clk   in   GMII byte clock; all logic runs on its rising edge
//   rst        in   synchronous reset, active-high
//   gmii_ctrl  in   TX_EN; high for preamble, SFD and frame bytes
//   gmii_data  in   GMII byte
//   rtc_time   in   free-running RTC time, sampled on the SFD cycle
//   ptp_found  out  one-cycle pulse: a complete PTP message was detected
//   ptp_event  out  qualifies ptp_found: messageType < 4
//   ptp_msgid  out  PTP messageType (low nibble of PTP byte 0)
//   ptp_seqid  out  PTP sequenceId (PTP bytes 30..31, big-endian)
//   ptp_ts     out  rtc_time captured on the SFD cycle of the reported frame
//   frame_err  out  one-cycle pulse: bad preamble/SFD or runt PTP frame
module gmii_ptp_parser #(
  parameter int TS_W    = 80,
  parameter int PRE_MAX = 7
) (
  input  logic            gmii_clk,
  input  logic            rst,
  input  logic            gmii_ctrl,
  input  logic [7:0]      gmii_data,
  input  logic [TS_W-1:0] rtc_time,
  output logic            ptp_found,
  output logic            ptp_event,
  output logic [3:0]      ptp_msgid,
  output logic [15:0]     ptp_seqid,
  output logic [TS_W-1:0] ptp_ts,
  output logic            frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_FRAME,
    S_DROP
  } state_t;

  localparam int PW = $clog2(PRE_MAX + 2);

  // Only the header bytes that the match needs are kept, not the whole frame.
  // Index : offset  ->  0:12 1:13 2:14 3:23 4:36 5:37 6:42 7:44 8:45 9:72 10:73
  // Tagged: 11:16 12:17 13:18 14:27 15:40 16:41 17:46 18:48 19:49 20:76 21:77
`ifdef GMII_PTP_VLAN_EN
  localparam int NCAP = 22;
  localparam logic [10:0] CAP_OFF [NCAP] = '{
    11'd12, 11'd13, 11'd14, 11'd23, 11'd36, 11'd37, 11'd42, 11'd44, 11'd45, 11'd72, 11'd73,
    11'd16, 11'd17, 11'd18, 11'd27, 11'd40, 11'd41, 11'd46, 11'd48, 11'd49, 11'd76, 11'd77
  };
`else
  localparam int NCAP = 11;
  localparam logic [10:0] CAP_OFF [NCAP] = '{
    11'd12, 11'd13, 11'd14, 11'd23, 11'd36, 11'd37, 11'd42, 11'd44, 11'd45, 11'd72, 11'd73
  };
`endif

  state_t          r_state;
  logic [PW-1:0]   r_preCnt;
  logic [10:0]     r_byteCnt;
  logic [TS_W-1:0] r_tsHold;
  logic [7:0]      r_cap [NCAP];

  state_t          w_nextState;
  logic [PW-1:0]   w_preNext;
  logic            w_errPulse;
  logic            w_foundPulse;
  logic            w_sfd;
  logic            w_match;
  logic [10:0]     w_need;
  logic [3:0]      w_msgId;
  logic [15:0]     w_seqId;
  logic [15:0]     w_type;

  function automatic logic isPtpPort(input logic [15:0] port);
    return (port == 16'h013F) || (port == 16'h0140);
  endfunction

  assign w_type = {r_cap[0], r_cap[1]};

  // Classify the frame from the captured header bytes. w_need is the minimum
  // frame length (PTP offset + 32) required to report the message.
  always_comb begin
    w_match = 1'b0;
    w_need  = 11'd0;
    w_msgId = 4'd0;
    w_seqId = 16'd0;
    if (w_type == 16'h88F7) begin
      w_match = 1'b1;
      w_need  = 11'd46;
      w_msgId = r_cap[2][3:0];
      w_seqId = {r_cap[7], r_cap[8]};
    end else if (w_type == 16'h0800 && r_cap[2] == 8'h45 && r_cap[3] == 8'h11 &&
                 isPtpPort({r_cap[4], r_cap[5]})) begin
      w_match = 1'b1;
      w_need  = 11'd74;
      w_msgId = r_cap[6][3:0];
      w_seqId = {r_cap[9], r_cap[10]};
    end
`ifdef GMII_PTP_VLAN_EN
    // A single tag only: an inner 0x8100 matches neither branch.
    else if (w_type == 16'h8100) begin
      if ({r_cap[11], r_cap[12]} == 16'h88F7) begin
        w_match = 1'b1;
        w_need  = 11'd50;
        w_msgId = r_cap[13][3:0];
        w_seqId = {r_cap[18], r_cap[19]};
      end else if ({r_cap[11], r_cap[12]} == 16'h0800 && r_cap[13] == 8'h45 &&
                   r_cap[14] == 8'h11 && isPtpPort({r_cap[15], r_cap[16]})) begin
        w_match = 1'b1;
        w_need  = 11'd78;
        w_msgId = r_cap[17][3:0];
        w_seqId = {r_cap[20], r_cap[21]};
      end
    end
`endif
  end

  // Next-state logic plus the pulse requests that get registered on the edge.
  always_comb begin
    w_nextState  = r_state;
    w_preNext    = r_preCnt;
    w_errPulse   = 1'b0;
    w_foundPulse = 1'b0;
    w_sfd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (gmii_ctrl) begin
          if (gmii_data == 8'h55) begin
            w_nextState = S_PRE;
            w_preNext   = PW'(1);
          end else begin
            w_nextState = S_DROP;
            w_errPulse  = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (!gmii_ctrl) begin
          w_nextState = S_IDLE;
          w_errPulse  = 1'b1;
        end else if (gmii_data == 8'h55) begin
          if (r_preCnt >= PW'(PRE_MAX)) begin
            w_nextState = S_DROP;
            w_errPulse  = 1'b1;
          end else begin
            w_preNext = r_preCnt + 1'b1;
          end
        end else if (gmii_data == 8'hD5) begin
          w_nextState = S_FRAME;
          w_sfd       = 1'b1;
        end else begin
          w_nextState = S_DROP;
          w_errPulse  = 1'b1;
        end
      end
      S_FRAME: begin
        if (!gmii_ctrl) begin
          w_nextState = S_IDLE;
          if (w_match) begin
            if (r_byteCnt >= w_need) w_foundPulse = 1'b1;
            else                     w_errPulse   = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (!gmii_ctrl) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge gmii_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Datapath: byte counting, header capture, and the registered results.
  // The capture bytes are cleared at each SFD, so a short frame can never
  // match on header bytes left over from an earlier frame.
  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      r_preCnt  <= '0;
      r_byteCnt <= '0;
      r_tsHold  <= '0;
      for (int i = 0; i < NCAP; i++) r_cap[i] <= 8'h00;
      ptp_found <= 1'b0;
      ptp_event <= 1'b0;
      ptp_msgid <= 4'd0;
      ptp_seqid <= 16'd0;
      ptp_ts    <= '0;
      frame_err <= 1'b0;
    end else begin
      r_preCnt  <= w_preNext;
      ptp_found <= w_foundPulse;
      frame_err <= w_errPulse;
      if (w_sfd) begin
        r_tsHold  <= rtc_time;
        r_byteCnt <= '0;
        for (int i = 0; i < NCAP; i++) r_cap[i] <= 8'h00;
      end else if (r_state == S_FRAME && gmii_ctrl) begin
        for (int i = 0; i < NCAP; i++) begin
          if (r_byteCnt == CAP_OFF[i]) r_cap[i] <= gmii_data;
        end
        if (r_byteCnt != 11'd2047) r_byteCnt <= r_byteCnt + 11'd1;
      end
      if (w_foundPulse) begin
        ptp_msgid <= w_msgId;
        ptp_seqid <= w_seqId;
        ptp_ts    <= r_tsHold;
        ptp_event <= (w_msgId < 4'd4);
      end
    end
  end

endmodule
